// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared definitions for the serial pattern generator.
//   state_e      - top-level FSM states (IDLE, SEND)
//   DEF_WIDTH    - default maximum pattern length in bits
//   DEF_LEN_W    - default width of the length input (2**DEF_LEN_W > DEF_WIDTH)
package seq_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_LEN_W = 4;

endpackage

// File: rtl/seq_gen_shift.sv
// seq_gen_shift: loadable MSB-first shift window with bit counter.
// Describes the bit the parent will drive on the next cycle (bit_nxt) and
// whether that bit closes the current copy of the pattern (last_nxt).
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   load          - latch pattern/length and consume the first bit
//   advance       - consume the next bit; wraps to a fresh copy when exhausted
//   pattern       - pattern bits, sampled on load
//   length        - number of bits (1..), clamped to WIDTH on load
//   bit_nxt       - bit to be driven after the coming edge
//   last_nxt      - bit_nxt is pattern[0] of its copy
//   wrap          - current copy fully consumed; next advance restarts it
module seq_gen_shift
   import seq_gen_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned LEN_W = DEF_LEN_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             advance,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] length,
   output logic             bit_nxt,
   output logic             last_nxt,
   output logic             wrap
);

   logic [WIDTH-1:0] pat_q, win_q, src;
   logic [LEN_W-1:0] len_q, cnt_q, len_c, src_cnt;

   // win_q holds the bits of the current copy not yet driven, left-aligned;
   // cnt_q is how many of them remain.
   always_comb begin
      len_c   = (length > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : length;
      wrap    = (cnt_q == '0);
      src     = win_q;
      src_cnt = cnt_q;
      if (load) begin
         src     = pattern << (LEN_W'(WIDTH) - len_c);
         src_cnt = len_c;
      end else if (wrap) begin
         src     = pat_q << (LEN_W'(WIDTH) - len_q);
         src_cnt = len_q;
      end
      bit_nxt  = src[WIDTH-1];
      last_nxt = (src_cnt == LEN_W'(1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pat_q <= '0;
         len_q <= '0;
         win_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         pat_q <= pattern;
         len_q <= len_c;
         win_q <= src << 1;
         cnt_q <= src_cnt - LEN_W'(1);
      end else if (advance) begin
         win_q <= src << 1;
         cnt_q <= src_cnt - LEN_W'(1);
      end
   end

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator. Sends pattern[L-1..0] MSB-first,
// repeat_cnt+1 times back to back, one bit per cycle.
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   start         - send request, accepted when ready=1 and length!=0
//   pattern       - bits to send, sampled on accept
//   length        - bits per copy, clamped to WIDTH, sampled on accept
//   repeat_cnt    - extra copies, sampled on accept
//   ready         - idle and able to accept start
//   data_out      - serial stream, IDLE_BIT when not sending
//   bit_valid     - data_out carries a pattern bit
//   done          - pulse on the final transmitted bit
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned LEN_W    = DEF_LEN_W,
   parameter logic        IDLE_BIT = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] length,
   input  logic [3:0]       repeat_cnt,
   output logic             ready,
   output logic             data_out,
   output logic             bit_valid,
   output logic             done
);

   state_e     state_q;
   logic [3:0] rep_q;
   logic       load, advance, bit_nxt, last_nxt, wrap;

   assign load    = (state_q == IDLE) && start && (length != '0);
   assign advance = (state_q == SEND) && !done;

   seq_gen_shift #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) u_shift (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .advance  (advance),
      .pattern  (pattern),
      .length   (length),
      .bit_nxt  (bit_nxt),
      .last_nxt (last_nxt),
      .wrap     (wrap)
   );

   // rep_q counts copies still to start after the current one; a copy
   // boundary (wrap) consumes one before the next bit is driven.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         rep_q     <= '0;
         ready     <= 1'b1;
         bit_valid <= 1'b0;
         done      <= 1'b0;
         data_out  <= IDLE_BIT;
      end else begin
         case (state_q)
            IDLE: begin
               if (load) begin
                  state_q   <= SEND;
                  rep_q     <= repeat_cnt;
                  ready     <= 1'b0;
                  bit_valid <= 1'b1;
                  data_out  <= bit_nxt;
                  done      <= last_nxt && (repeat_cnt == 4'd0);
               end
            end
            SEND: begin
               if (done) begin
                  state_q   <= IDLE;
                  ready     <= 1'b1;
                  bit_valid <= 1'b0;
                  done      <= 1'b0;
                  data_out  <= IDLE_BIT;
               end else begin
                  if (wrap) begin
                     rep_q <= rep_q - 4'd1;
                  end
                  data_out <= bit_nxt;
                  done     <= last_nxt && (wrap ? (rep_q == 4'd1) : (rep_q == 4'd0));
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed, scoreboard-checked bench for seq_gen.
// Expected per-cycle outputs are queued as stimulus is driven and popped
// one per clock, sampled 1 time unit after the rising edge.
module tb_seq_gen;

   localparam int unsigned WIDTH    = 8;
   localparam logic        IDLE_BIT = 1'b1;

   logic       clock = 1'b0;
   logic       reset, start;
   logic [7:0] pattern;
   logic [3:0] length, repeat_cnt;
   logic       ready, data_out, bit_valid, done;

   typedef struct packed {
      logic d;
      logic v;
      logic dn;
      logic rdy;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   found  = 0;
   logic [4:0] hist = 5'b11111;

   always #5 clock = ~clock;

   seq_gen dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .pattern    (pattern),
      .length     (length),
      .repeat_cnt (repeat_cnt),
      .ready      (ready),
      .data_out   (data_out),
      .bit_valid  (bit_valid),
      .done       (done)
   );

   // Downstream 00001 detector watching the raw line every cycle.
   always @(negedge clock) begin
      if ({hist[3:0], data_out} == 5'b00001) found++;
      hist = {hist[3:0], data_out};
   end

   task automatic push_idle();
      exp_q.push_back({IDLE_BIT, 1'b0, 1'b0, 1'b1});
   endtask

   task automatic push_send(input logic [7:0] pat, input int len, input int rep);
      int lc;
      lc = (len > int'(WIDTH)) ? int'(WIDTH) : len;
      for (int c = 0; c <= rep; c++) begin
         for (int i = lc - 1; i >= 0; i--) begin
            exp_q.push_back({pat[i], 1'b1, (c == rep) && (i == 0), 1'b0});
         end
      end
   endtask

   task automatic check(input string tag);
      obs_t e, o;
      @(posedge clock);
      #1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      o = {data_out, bit_valid, done, ready};
      checks++;
      assert (o === e) passed++;
      else $error("FAIL %s: observed d/v/done/rdy=%b required=%b", tag, o, e);
   endtask

   task automatic run_send(input string tag, input logic [7:0] pat, input int len,
                           input int rep, input bit hold);
      int lc;
      lc         = (len > int'(WIDTH)) ? int'(WIDTH) : len;
      pattern    = pat;
      length     = 4'(len);
      repeat_cnt = 4'(rep);
      start      = 1'b1;
      push_send(pat, len, rep);
      push_idle();
      for (int k = 0; k < lc * (rep + 1) + 1; k++) begin
         check(tag);
         if (k == 0) begin
            // Disturb every input after accept; the transfer must not notice.
            if (!hold) start = 1'b0;
            pattern    = ~pat;
            length     = 4'd3;
            repeat_cnt = 4'hF;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int f0;
      reset = 1'b1; start = 1'b0; pattern = '0; length = '0; repeat_cnt = '0;
      @(posedge clock);
      #1;
      push_idle(); check("reset");
      reset = 1'b0;
      push_idle(); check("idle");

      run_send("p01_len5", 8'h01, 5, 0, 1'b0);
      run_send("pB5_rep2", 8'hB5, 8, 2, 1'b0);
      run_send("hold_start", 8'h5A, 6, 1, 1'b1);

      // length 0 is ignored
      start = 1'b1; pattern = 8'hFF; length = 4'd0; repeat_cnt = 4'd1;
      push_idle(); check("len0_a");
      push_idle(); check("len0_b");
      start = 1'b0;
      push_idle(); check("len0_c");

      run_send("len12_clamp", 8'hA6, 12, 0, 1'b0);
      run_send("len1_rep3", 8'h03, 1, 3, 1'b0);

      // reset at bit 3 of an 8-bit send: abort, no done
      pattern = 8'hC3; length = 4'd8; repeat_cnt = 4'd0; start = 1'b1;
      exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0});
      exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0});
      exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0});
      check("abort_b1");
      start = 1'b0;
      check("abort_b2");
      check("abort_b3");
      reset = 1'b1;
      push_idle(); check("abort_rst");
      reset = 1'b0;
      push_idle(); check("abort_after");

      // reset and start together: reset wins
      reset = 1'b1; start = 1'b1; pattern = 8'h0F; length = 4'd4;
      push_idle(); check("rst_start");
      reset = 1'b0; start = 1'b0;
      push_idle(); check("rst_start_after");

      // detector sees exactly one 00001 per copy, none from idle 1s
      f0 = found;
      run_send("det_stream", 8'h01, 5, 2, 1'b0);
      push_idle(); check("det_idle");
      checks++;
      assert ((found - f0) === 3) passed++;
      else $error("FAIL det_count: observed %0d required 3", found - f0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
Parameters:
REQ-001 WIDTH, 8, maximum pattern length in bits.
REQ-002 LEN_W, 4, width of the length input; SHALL satisfy 2**LEN_W > WIDTH.
REQ-003 IDLE_BIT, 1'b1, level driven on data_out when no bit is being sent.

Ports:
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to send; accepted only when ready=1.
REQ-007 pattern  input  WIDTH  bits to send, sampled on accept.
REQ-008 length  input  LEN_W  number of bits to send (1..WIDTH), sampled on accept.
REQ-009 repeat_cnt  input  4  extra repetitions; the pattern is sent repeat_cnt+1 times.
REQ-010 ready  output  1  high when idle and able to accept start.
REQ-011 data_out  output  1  serial bit stream.
REQ-012 bit_valid  output  1  high in every cycle data_out carries a pattern bit.
REQ-013 done  output  1  one-cycle pulse coinciding with the final transmitted bit.

Function
REQ-014 FSM states: IDLE, SEND. The block SHALL have no other states.
REQ-015 IDLE: ready=1, bit_valid=0, done=0, data_out=IDLE_BIT.
REQ-016 Accept condition: start=1, ready=1 and length!=0. On accept, latch pattern, length and repeat_cnt, and move to SEND.
REQ-017 start with length=0 SHALL be ignored: stay in IDLE, no done pulse.
REQ-018 length>WIDTH SHALL be clamped to WIDTH on accept.
REQ-019 Latency: the first bit appears on data_out in the cycle after accept.
REQ-020 Bit order: MSB-first within the window, i.e. pattern[L-1] down to pattern[0], one bit per cycle; bit_valid=1 throughout.
REQ-021 Repeats: after pattern[0], the window restarts at pattern[L-1] in the next cycle with no gap, until repeat_cnt+1 copies are sent.
REQ-022 Total SEND duration: exactly L*(repeat_cnt+1) cycles.
REQ-023 done=1 only in the cycle the last bit of the last copy is driven.
REQ-024 After that cycle, the FSM returns to IDLE and ready=1.
REQ-025 ready=0 throughout SEND; start during SEND is ignored and does not alter latched values.
REQ-026 Input changes on pattern, length or repeat_cnt after accept SHALL NOT affect the transmission in progress.
REQ-027 Bit-index counter width is LEN_W; repeat counter width is 4; neither counter may wrap outside its defined range.

Reset
REQ-028 reset=1 at a rising edge forces IDLE, clears all counters and latches, and drives ready=1, bit_valid=0, done=0, data_out=IDLE_BIT in the following cycle.
REQ-029 If reset and start are high in the same cycle, reset wins; nothing is accepted.
REQ-030 Reset during SEND aborts the transmission immediately, with no done pulse.

Structure
REQ-031 Package seq_gen_pkg holds the state enumeration (IDLE, SEND) and the default WIDTH/LEN_W constants.
REQ-032 One sub-module, seq_gen_shift, holds the loadable MSB-first shift window and bit counter.
REQ-033 The top level holds the FSM, repeat counter, handshake and output muxing.
REQ-034 All outputs are registered.

Verification
REQ-035 pattern=8'h01, length=5, repeat=0, start pulse: data_out=0,0,0,0,1 over the 5 cycles after accept; done in cycle 5; ready=1 in cycle 6.
REQ-036 pattern=8'hB5, length=8, repeat=2: 24 consecutive valid bits 10110101 x3, no gap; a single done on bit 24.
REQ-037 start held high during SEND and pattern changed mid-stream: output unchanged; no second accept until ready returns.
REQ-038 length=0 with start: ready stays 1, bit_valid and done stay 0; length=12 with WIDTH=8: exactly 8 bits sent.
REQ-039 reset asserted at bit 3 of an 8-bit send: next cycle IDLE outputs (data_out=1, bit_valid=0, ready=1); no done pulse.
REQ-040 seq_gen output drives a seqdec instance with pattern 00001: found_flag asserts once per sent copy; idle level 1 causes no false detection.
